// File: rtl/wb2axil_bridge.sv
`default_nettype none
// =============================================================================
// wb2axil_bridge : Wishbone classic slave to AXI4-Lite master, one request in flight
// Revision       : 1.0
// =============================================================================
module wb2axil_bridge #(
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  // Wishbone slave
  input  logic [AW-3:0] i_wb_adr,
  input  logic [31:0]   i_wb_dat,
  input  logic [3:0]    i_wb_sel,
  input  logic          i_wb_we,
  input  logic          i_wb_cyc,
  input  logic          i_wb_stb,
  output logic [31:0]   o_wb_rdt,
  output logic          o_wb_ack,
  output logic          o_wb_err,
  // AXI4-Lite write address / data / response
  output logic [AW-1:0] o_awaddr,
  output logic          o_awvalid,
  input  logic          i_awready,
  output logic [63:0]   o_wdata,
  output logic [7:0]    o_wstrb,
  output logic          o_wvalid,
  input  logic          i_wready,
  input  logic [1:0]    i_bresp,
  input  logic          i_bvalid,
  output logic          o_bready,
  // AXI4-Lite read address / data
  output logic [AW-1:0] o_araddr,
  output logic          o_arvalid,
  input  logic          i_arready,
  input  logic [63:0]   i_rdata,
  input  logic [1:0]    i_rresp,
  input  logic          i_rvalid,
  output logic          o_rready
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_BRESP = 3'd2,
    S_READ  = 3'd3,
    S_RRESP = 3'd4
  } state_t;

  state_t        r_state;
  logic [AW-1:0] r_addr;
  logic [63:0]   r_wdata;
  logic [7:0]    r_wstrb;
  logic [31:0]   r_rdt;
  logic          r_awvalid;
  logic          r_wvalid;
  logic          r_bready;
  logic          r_arvalid;
  logic          r_rready;
  logic          r_ack;
  logic          r_err;

  logic          w_req;
  logic          w_aw_fin;
  logic          w_w_fin;
  logic          w_unused;

  // A request is not re-accepted while its own completion pulse is still visible.
  assign w_req    = i_wb_cyc & i_wb_stb & ~o_wb_ack & ~o_wb_err;
  assign w_aw_fin = ~r_awvalid | i_awready;
  assign w_w_fin  = ~r_wvalid  | i_wready;
  assign w_unused = i_bresp[0] ^ i_rresp[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_rdt     <= '0;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_bready  <= 1'b0;
      r_arvalid <= 1'b0;
      r_rready  <= 1'b0;
      r_ack     <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_ack <= 1'b0;
      r_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_addr <= {i_wb_adr, 2'b00};
            if (i_wb_we) begin
              r_wdata   <= {i_wb_dat, i_wb_dat};
              r_wstrb   <= i_wb_adr[0] ? {i_wb_sel, 4'b0000} : {4'b0000, i_wb_sel};
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_state   <= S_WRITE;
            end else begin
              r_arvalid <= 1'b1;
              r_state   <= S_READ;
            end
          end
        end
        S_WRITE: begin
          if (r_awvalid && i_awready) r_awvalid <= 1'b0;
          if (r_wvalid && i_wready)   r_wvalid  <= 1'b0;
          // AW and W may finish in either order or on the same edge.
          if (w_aw_fin && w_w_fin) begin
            r_bready <= 1'b1;
            r_state  <= S_BRESP;
          end
        end
        S_BRESP: begin
          if (i_bvalid) begin
            r_bready <= 1'b0;
            r_ack    <= ~i_bresp[1];
            r_err    <= i_bresp[1];
            r_state  <= S_IDLE;
          end
        end
        S_READ: begin
          if (i_arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= S_RRESP;
          end
        end
        S_RRESP: begin
          if (i_rvalid) begin
            r_rready <= 1'b0;
            r_rdt    <= r_addr[2] ? i_rdata[63:32] : i_rdata[31:0];
            r_ack    <= ~i_rresp[1];
            r_err    <= i_rresp[1];
            r_state  <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Completion is swallowed if the master has abandoned the cycle.
  assign o_wb_ack  = r_ack & i_wb_cyc;
  assign o_wb_err  = r_err & i_wb_cyc;
  assign o_wb_rdt  = r_rdt;
  assign o_awaddr  = r_addr;
  assign o_araddr  = r_addr;
  assign o_awvalid = r_awvalid;
  assign o_wvalid  = r_wvalid;
  assign o_wdata   = r_wdata;
  assign o_wstrb   = r_wstrb;
  assign o_bready  = r_bready;
  assign o_arvalid = r_arvalid;
  assign o_rready  = r_rready;

endmodule
`default_nettype wire

// File: tb/tb_wb2axil_bridge.sv
`default_nettype none
// tb_wb2axil_bridge : randomized WB master + AXI-Lite slave memory vs. word-level model.
module tb_wb2axil_bridge;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [29:0] i_wb_adr = '0;
  logic [31:0] i_wb_dat = '0;
  logic [3:0]  i_wb_sel = '0;
  logic        i_wb_we = 1'b0, i_wb_cyc = 1'b0, i_wb_stb = 1'b0;
  logic [31:0] o_wb_rdt;
  logic        o_wb_ack, o_wb_err;
  logic [31:0] o_awaddr, o_araddr;
  logic        o_awvalid, o_wvalid, o_bready, o_arvalid, o_rready;
  logic        i_awready = 1'b0, i_wready = 1'b0, i_bvalid = 1'b0;
  logic        i_arready = 1'b0, i_rvalid = 1'b0;
  logic [63:0] o_wdata;
  logic [7:0]  o_wstrb;
  logic [1:0]  i_bresp = '0, i_rresp = '0;
  logic [63:0] i_rdata = '0;

  int n_checks = 0;
  int n_errors = 0;

  logic [63:0] mem   [0:15];   // AXI slave storage, 64-bit lanes
  logic [31:0] ref32 [0:31];   // expected Wishbone-visible word contents

  always #5 clk = ~clk;

  wb2axil_bridge #(.AW(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_wb_adr(i_wb_adr), .i_wb_dat(i_wb_dat), .i_wb_sel(i_wb_sel), .i_wb_we(i_wb_we),
    .i_wb_cyc(i_wb_cyc), .i_wb_stb(i_wb_stb), .o_wb_rdt(o_wb_rdt), .o_wb_ack(o_wb_ack),
    .o_wb_err(o_wb_err), .o_awaddr(o_awaddr), .o_awvalid(o_awvalid), .i_awready(i_awready),
    .o_wdata(o_wdata), .o_wstrb(o_wstrb), .o_wvalid(o_wvalid), .i_wready(i_wready),
    .i_bresp(i_bresp), .i_bvalid(i_bvalid), .o_bready(o_bready), .o_araddr(o_araddr),
    .o_arvalid(o_arvalid), .i_arready(i_arready), .i_rdata(i_rdata), .i_rresp(i_rresp),
    .i_rvalid(i_rvalid), .o_rready(o_rready)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Completion pulses must be exclusive and one cycle wide.
  logic prev_pulse = 1'b0;
  always @(negedge clk) begin
    if (o_wb_ack || o_wb_err) begin
      check_val("ack_err_exclusive", 64'(o_wb_ack & o_wb_err), 64'd0);
      check_val("pulse_single_cycle", 64'(prev_pulse), 64'd0);
    end
    prev_pulse = o_wb_ack | o_wb_err;
  end

  task automatic wb_idle();
    i_wb_cyc = 1'b0;
    i_wb_stb = 1'b0;
    @(negedge clk);
  endtask

  // One Wishbone request; the bench plays the AXI slave with the given delays.
  task automatic run_txn(input bit we, input logic [29:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, input int aw_d, input int w_d, input int r_d,
                         input logic [1:0] resp, input bit drop_cyc, input int exp_lat);
    int n = 0, tail = 0;
    int aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, r_hs = 0;
    int aw_c = 0, w_c = 0, b_c = 0, r_c = 0;
    bit got_ack = 0, got_err = 0, done = 0;
    logic [31:0] cap_awaddr = '0, cap_araddr = '0;
    logic [63:0] cap_wdata = '0;
    logic [7:0]  cap_wstrb = '0;
    logic [7:0]  exp_strb;
    exp_strb = 8'(sel) << (4 * int'(adr[0]));
    i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = we;
    i_wb_adr = adr;  i_wb_dat = dat;  i_wb_sel = sel;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
      if (o_wb_ack || o_wb_err) begin
        got_ack = o_wb_ack;
        got_err = o_wb_err;
        done = 1;
        if (exp_lat > 0) check_val("ack_latency", 64'(n), 64'(exp_lat));
      end
      if (drop_cyc && n == 1) begin
        i_wb_cyc = 1'b0;
        i_wb_stb = 1'b0;
      end
      // responses first, so they see only handshakes from earlier edges
      if (we && aw_hs > 0 && w_hs > 0 && b_hs == 0) begin
        if (b_c >= r_d) begin
          i_bvalid = 1'b1; i_bresp = resp;
          if (o_bready) begin
            b_hs++;
            if (!resp[1])
              for (int b = 0; b < 8; b++)
                if (cap_wstrb[b]) mem[cap_awaddr[6:3]][8*b +: 8] = cap_wdata[8*b +: 8];
          end
        end else begin
          b_c++; i_bvalid = 1'b0;
        end
      end else begin
        i_bvalid = 1'b0; i_bresp = 2'b00;
      end
      if (!we && ar_hs > 0 && r_hs == 0) begin
        if (r_c >= r_d) begin
          i_rvalid = 1'b1; i_rresp = resp; i_rdata = mem[cap_araddr[6:3]];
          if (o_rready) r_hs++;
        end else begin
          r_c++; i_rvalid = 1'b0; i_rdata = {$urandom, $urandom};
        end
      end else begin
        i_rvalid = 1'b0; i_rresp = 2'b00; i_rdata = {$urandom, $urandom};
      end
      if (o_awvalid) begin
        if (aw_c >= aw_d) begin i_awready = 1'b1; aw_hs++; cap_awaddr = o_awaddr; end
        else begin i_awready = 1'b0; aw_c++; end
      end else i_awready = 1'b0;
      if (o_wvalid) begin
        if (w_c >= w_d) begin
          i_wready = 1'b1; w_hs++; cap_wdata = o_wdata; cap_wstrb = o_wstrb;
        end else begin i_wready = 1'b0; w_c++; end
      end else i_wready = 1'b0;
      if (o_arvalid) begin
        if (aw_c >= aw_d) begin i_arready = 1'b1; ar_hs++; cap_araddr = o_araddr; end
        else begin i_arready = 1'b0; aw_c++; end
      end else i_arready = 1'b0;
      if (drop_cyc && (b_hs + r_hs) > 0) begin
        tail++;
        if (tail > 3) done = 1;
      end
    end
    check_val("txn_completed", 64'(done), 64'd1);
    if (we) begin
      check_val("aw_handshakes", 64'(aw_hs), 64'd1);
      check_val("w_handshakes", 64'(w_hs), 64'd1);
      check_val("b_handshakes", 64'(b_hs), 64'd1);
      check_val("ar_on_write", 64'(ar_hs), 64'd0);
      check_val("awaddr", 64'(cap_awaddr), 64'(adr) * 4);
      check_val("wdata", cap_wdata, {32'd0, dat} * 64'h1_0000_0001);
      check_val("wstrb", 64'(cap_wstrb), 64'(exp_strb));
    end else begin
      check_val("ar_handshakes", 64'(ar_hs), 64'd1);
      check_val("r_handshakes", 64'(r_hs), 64'd1);
      check_val("aw_on_read", 64'(aw_hs), 64'd0);
      check_val("araddr", 64'(cap_araddr), 64'(adr) * 4);
    end
    if (drop_cyc) begin
      check_val("pulse_suppressed", 64'(got_ack | got_err), 64'd0);
    end else begin
      check_val("ack", 64'(got_ack), 64'(!resp[1]));
      check_val("err", 64'(got_err), 64'(resp[1]));
      if (!we && !resp[1]) check_val("read_data", 64'(o_wb_rdt), 64'(ref32[adr]));
    end
    if (we && !resp[1])
      for (int b = 0; b < 4; b++)
        if (sel[b]) ref32[adr][8*b +: 8] = dat[8*b +: 8];
  endtask

  initial begin
    bit          t_we, t_drop;
    logic [29:0] t_adr;
    logic [1:0]  t_resp;
    bit          saw_pulse;

    for (int i = 0; i < 16; i++) mem[i] = '0;
    for (int i = 0; i < 32; i++) ref32[i] = '0;
    mem[0]   = 64'h1111_2222_3333_4444;
    ref32[0] = 32'h3333_4444;
    ref32[1] = 32'h1111_2222;

    repeat (3) @(negedge clk);
    check_val("reset_valids", 64'({o_awvalid, o_wvalid, o_arvalid, o_bready, o_rready}), 64'd0);
    check_val("reset_pulses", 64'({o_wb_ack, o_wb_err}), 64'd0);
    check_val("reset_addr", 64'(o_awaddr | o_araddr), 64'd0);
    check_val("reset_wdata_wstrb", o_wdata | 64'(o_wstrb), 64'd0);
    check_val("reset_rdt", 64'(o_wb_rdt), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // directed: minimum-latency read and write, then readback
    run_txn(0, 30'h000, 32'h0, 4'h0, 0, 0, 0, 2'b00, 0, 3);
    wb_idle();
    run_txn(1, 30'h001, 32'hA5A5_1234, 4'hF, 0, 0, 0, 2'b00, 0, 3);
    wb_idle();
    run_txn(0, 30'h001, 32'h0, 4'h0, 0, 0, 0, 2'b00, 0, 3);
    wb_idle();
    // W accepted 3 cycles before AW, B delayed 5 cycles
    run_txn(1, 30'h006, 32'hDEAD_BEEF, 4'h5, 3, 0, 5, 2'b00, 0, 0);
    wb_idle();
    // sel=0 write still goes out with zero strobes
    run_txn(1, 30'h002, 32'hFFFF_FFFF, 4'h0, 0, 0, 0, 2'b00, 0, 3);
    run_txn(0, 30'h002, 32'h0, 4'h0, 1, 0, 2, 2'b00, 0, 0);
    // error responses
    run_txn(0, 30'h003, 32'h0, 4'h0, 0, 0, 1, 2'b10, 0, 0);
    run_txn(1, 30'h004, 32'h1234_5678, 4'hF, 1, 2, 0, 2'b11, 0, 0);
    wb_idle();

    // reset while AW is pending
    i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = 1'b1;
    i_wb_adr = 30'h005; i_wb_dat = 32'hCAFE_F00D; i_wb_sel = 4'hF;
    @(negedge clk);
    check_val("pre_reset_awvalid", 64'(o_awvalid), 64'd1);
    rst_n = 1'b0;
    #1;
    check_val("async_reset_valids", 64'({o_awvalid, o_wvalid}), 64'd0);
    i_wb_cyc = 1'b0; i_wb_stb = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    saw_pulse = 0;
    repeat (4) begin
      @(negedge clk);
      saw_pulse |= o_wb_ack | o_wb_err | o_awvalid | o_wvalid;
    end
    check_val("quiet_after_reset", 64'(saw_pulse), 64'd0);
    check_val("addr_after_reset", 64'(o_awaddr), 64'd0);
    run_txn(1, 30'h005, 32'hCAFE_F00D, 4'hF, 0, 0, 0, 2'b00, 0, 3);
    wb_idle();

    // randomized traffic, often back-to-back with stb held high
    for (int t = 0; t < 40; t++) begin
      t_we   = 1'($urandom_range(0, 1));
      t_adr  = 30'($urandom_range(0, 31));
      t_drop = ($urandom_range(0, 9) == 0);
      t_resp = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
      if (t_drop || $urandom_range(0, 2) == 0) wb_idle();
      run_txn(t_we, t_adr, $urandom, 4'($urandom), $urandom_range(0, 4),
              $urandom_range(0, 4), $urandom_range(0, 4), t_resp, t_drop, 0);
    end
    wb_idle();
    repeat (3) @(negedge clk);
    check_val("final_idle", 64'({o_awvalid, o_wvalid, o_arvalid, o_bready, o_rready}), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
